// File: rtl/bitwise_alu_pipe.sv
// rtl/bitwise_alu_pipe.sv - bitwise ALU with a 2-entry in-order result buffer
// Valid/ready on both sides; in_ready depends only on stored occupancy.
module bitwise_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
  } entry_t;

  localparam entry_t ENTRY_RST = '{result: '0, zero: 1'b1, parity: 1'b0};

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  entry_t           new_entry;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] op_count_q;
  logic [WIDTH-1:0] alu_res;
  logic             push;
  logic             pop;

  always_comb begin
    alu_res = '0;
    case (in_op)
      3'b000:  alu_res = in_a & in_b;
      3'b001:  alu_res = in_a | in_b;
      3'b010:  alu_res = in_a ^ in_b;
      3'b011:  alu_res = ~(in_a & in_b);
      3'b100:  alu_res = ~(in_a | in_b);
      3'b101:  alu_res = ~(in_a ^ in_b);
      3'b110:  alu_res = ~in_a;
      default: alu_res = in_b;
    endcase
  end

  assign new_entry = '{result: alu_res, zero: (alu_res == '0), parity: ^alu_res};

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // Head is always slot 0; a pop from a full buffer shifts the tail forward.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = new_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      head_q     <= ENTRY_RST;
      tail_q     <= ENTRY_RST;
      op_count_q <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (push) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign out_result = head_q.result;
  assign out_zero   = head_q.zero;
  assign out_parity = head_q.parity;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// tb/tb_bitwise_alu_pipe.sv - self-checking bench for bitwise_alu_pipe
module tb_bitwise_alu_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_parity;
  logic [CNT_W-1:0] op_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bitwise_alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .op_count   (op_count)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
    logic       parity;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = 3'b000;
    in_a      = '0;
    in_b      = '0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 8'hA5, 8'h0F, 8'h0F, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{3'b111, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b1};
    vecs[11] = '{3'b001, 8'h80, 8'h03, 8'h83, 1'b0, 1'b1};
    vecs[12] = '{3'b110, 8'hFF, 8'h5A, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{3'b101, 8'h12, 8'h34, 8'hD9, 1'b0, 1'b1};

    // Reset values are checked while rst_n is still low.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'b000; in_a = '0; in_b = '0;
    #12;
    chk("rst_in_ready",  in_ready,   1);
    chk("rst_out_valid", out_valid,  0);
    chk("rst_op_count",  op_count,   0);
    chk("rst_result",    out_result, 0);
    chk("rst_zero",      out_zero,   1);
    chk("rst_parity",    out_parity, 0);
    rst_n = 1'b1;

    // Empty buffer ignores out_ready.
    cycle();
    chk("empty_out_valid", out_valid, 0);

    // Single operation, then drain.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 8'hF0, 8'h3C);
    cycle();
    chk("single_valid",  out_valid,  1);
    chk("single_result", out_result, 8'hCC);
    chk("single_zero",   out_zero,   0);
    chk("single_parity", out_parity, 0);
    chk("single_count",  op_count,   1);
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    cycle();
    chk("single_drained", out_valid, 0);

    // Back-to-back table with continuous consumption.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      cycle();
      chk($sformatf("vec%0d_valid", i),  out_valid,  1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i),   out_zero,   vecs[i].zero);
      chk($sformatf("vec%0d_parity", i), out_parity, vecs[i].parity);
      chk($sformatf("vec%0d_ready", i),  in_ready,   1);
      if (i == 7) chk("all_ops_count", op_count, 8);
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    cycle();
    chk("table_count", op_count, 14);
    chk("table_drained", out_valid, 0);

    // Backpressure: two accepted, third held until space frees up.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 8'h00, 8'h11);
    cycle();
    chk("bp1_ready", in_ready, 1);
    chk("bp1_head",  out_result, 8'h11);
    drive(1'b1, 3'b111, 8'h00, 8'h22);
    cycle();
    chk("bp2_ready", in_ready, 0);
    chk("bp2_head",  out_result, 8'h11);
    drive(1'b1, 3'b111, 8'h00, 8'h33);
    cycle();
    chk("bp3_ready", in_ready, 0);
    chk("bp3_hold",  out_result, 8'h11);
    chk("bp3_count", op_count, 2);
    out_ready = 1'b1;
    cycle();
    chk("bp4_head",  out_result, 8'h22);
    chk("bp4_ready", in_ready, 1);
    chk("bp4_count", op_count, 2);
    cycle();
    chk("bp5_head",  out_result, 8'h33);
    chk("bp5_valid", out_valid, 1);
    chk("bp5_count", op_count, 3);
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    cycle();
    chk("bp6_drained", out_valid, 0);

    // Reset between edges flushes a full buffer at once.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 8'h00, 8'h44);
    cycle();
    drive(1'b1, 3'b111, 8'h00, 8'h55);
    cycle();
    chk("mid_full", in_ready, 0);
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready",  in_ready,  1);
    chk("mid_op_count",  op_count,  0);
    #1;
    rst_n = 1'b1;

    // Counter wraps: 17 accepts on a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'b000, 8'(i), 8'hFF);
      cycle();
      if (i == 15) chk("wrap_zero", op_count, 0);
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("wrap_count", op_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
